// File: rtl/mac_sequencer_pkg.sv
// Shared definitions for the MAC sequencer slice.
// Contents:
//   state_t     - sequencer FSM encodings (3-bit)
//   mode_t      - operation selected by the start pulse (multiply or add)
//   MAX_RESULTS - result RAM depth; an operation stops once this many results are written
package mac_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_POP      = 3'd1,
      ST_LOAD     = 3'd2,
      ST_MUL_WAIT = 3'd3,
      ST_WRITE    = 3'd4,
      ST_DONE     = 3'd5
   } state_t;

   typedef enum logic {
      MODE_MUL = 1'b0,
      MODE_ADD = 1'b1
   } mode_t;

   localparam int MAX_RESULTS = 8;

endpackage

// File: rtl/mac_sequencer_cla32.sv
// cla32: carry-lookahead adder used by the sequencer's ADD path.
// The adder is built from 4-bit groups. Each group forms a group generate and a
// group propagate, and the carry into the next group comes from those two terms.
// Ports:
//   a, b  in   WIDTH  addends
//   cin   in   1      carry in
//   sum   out  WIDTH  a + b + cin, truncated to WIDTH bits
//   cout  out  1      carry out of the top bit
module cla32 #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int GROUPS = WIDTH / 4;

   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] p;

   assign g = a & b;
   assign p = a ^ b;

   // Bit carries inside each group ripple from the group's carry-in.
   // The carry leaving the group is produced from the lookahead terms instead.
   always_comb begin : carry_blk
      logic [WIDTH:0] c;
      logic           grp_g;
      logic           grp_p;
      c     = '0;
      grp_g = 1'b0;
      grp_p = 1'b0;
      c[0]  = cin;
      for (int k = 0; k < GROUPS; k++) begin
         grp_g = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         grp_p = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
         for (int j = 0; j < 3; j++) begin
            c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
         end
         c[4*k+4] = grp_g | (grp_p & c[4*k]);
      end
      sum  = p ^ c[WIDTH-1:0];
      cout = c[WIDTH];
   end

endmodule

// File: rtl/mac_sequencer.sv
// mac_sequencer: pops operand pairs from the two operand FIFOs, then either
// multiplies them (using the external multi-cycle multiplier) or adds them.
// Each result is written to the result RAM. When the operation ends, the block
// holds adder_op_done high until it is cleared or restarted.
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   multi_op_start / adder_op_start    1-cycle start pulses (multiply wins if both arrive together)
//   op_clear                           abort; the FSM returns to IDLE on the next edge
//   fifo_data_count0/1                 occupancy of FIFO B / FIFO A
//   multiplicand_re / multiplier_re    FIFO pops; read data arrives one cycle later
//   mul_start, mul_a, mul_b            multiplier launch and its held operands
//   mul_done, mul_result               multiplier completion pulse and product
//   res_we, res_waddr, res_wdata       result RAM write port
//   res_count                          number of results written in the current operation
//   adder_op_done, busy                status
module mac_sequencer
   import mac_sequencer_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 3,
   parameter int CNT_W  = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                multi_op_start,
   input  logic                adder_op_start,
   input  logic                op_clear,
   input  logic [CNT_W-1:0]    fifo_data_count0,
   input  logic [CNT_W-1:0]    fifo_data_count1,
   output logic                multiplicand_re,
   output logic                multiplier_re,
   input  logic [DATA_W-1:0]   multiplicand_q,
   input  logic [DATA_W-1:0]   multiplier_q,
   output logic                mul_start,
   output logic [DATA_W-1:0]   mul_a,
   output logic [DATA_W-1:0]   mul_b,
   input  logic                mul_done,
   input  logic [2*DATA_W-1:0] mul_result,
   output logic                res_we,
   output logic [ADDR_W-1:0]   res_waddr,
   output logic [DATA_W-1:0]   res_wdata,
   output logic [CNT_W-1:0]    res_count,
   output logic                adder_op_done,
   output logic                busy
);

   state_t             state_q, state_d;
   mode_t              mode_q, mode_d;
   logic [ADDR_W-1:0]  wptr_q, wptr_d;
   logic [CNT_W-1:0]   res_count_q, res_count_d;
   logic [DATA_W-1:0]  a_q, a_d;
   logic [DATA_W-1:0]  b_q, b_d;
   logic [DATA_W-1:0]  prod_q, prod_d;
   logic               re_q, re_d;
   logic               mul_start_q, mul_start_d;
   logic [DATA_W-1:0]  sum;
   logic               unused_cout;
   logic               unused_prod_hi;

   cla32 #(.WIDTH(DATA_W)) u_add (
      .a    (a_q),
      .b    (b_q),
      .cin  (1'b0),
      .sum  (sum),
      .cout (unused_cout)
   );

   // Only the low half of the product goes to the result RAM.
   assign unused_prod_hi = ^mul_result[2*DATA_W-1:DATA_W];

   // Next-state logic. op_clear overrides everything. Start pulses are accepted
   // only in IDLE or DONE, so a pulse that arrives while busy has no effect.
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      wptr_d      = wptr_q;
      res_count_d = res_count_q;
      a_d         = a_q;
      b_d         = b_q;
      prod_d      = prod_q;
      mul_start_d = 1'b0;
      if (op_clear) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (multi_op_start) begin
                  mode_d      = MODE_MUL;
                  state_d     = ST_POP;
                  wptr_d      = '0;
                  res_count_d = '0;
               end else if (adder_op_start) begin
                  mode_d      = MODE_ADD;
                  state_d     = ST_POP;
                  wptr_d      = '0;
                  res_count_d = '0;
               end
            end
            ST_POP: begin
               // re_q holds the pop decision made on the edge into POP.
               state_d = re_q ? ST_LOAD : ST_DONE;
            end
            ST_LOAD: begin
               a_d = multiplicand_q;
               b_d = multiplier_q;
               if (mode_q == MODE_MUL) begin
                  mul_start_d = 1'b1;
                  state_d     = ST_MUL_WAIT;
               end else begin
                  state_d = ST_WRITE;
               end
            end
            ST_MUL_WAIT: begin
               if (mul_done) begin
                  prod_d  = mul_result[DATA_W-1:0];
                  state_d = ST_WRITE;
               end
            end
            ST_WRITE: begin
               wptr_d      = wptr_q + ADDR_W'(1);
               res_count_d = res_count_q + CNT_W'(1);
               state_d     = ST_POP;
            end
            default: state_d = ST_IDLE;
         endcase
      end
      // The pop decision is registered, so the read enables stay pure flop outputs.
      // It is decided on the edge that enters POP, using the counts and the updated
      // result count seen at that edge.
      re_d = (state_d == ST_POP)
           && (fifo_data_count0 != '0)
           && (fifo_data_count1 != '0)
           && (res_count_d < CNT_W'(MAX_RESULTS));
   end

   // State, counter and operand registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         mode_q      <= MODE_MUL;
         wptr_q      <= '0;
         res_count_q <= '0;
         a_q         <= '0;
         b_q         <= '0;
         prod_q      <= '0;
         re_q        <= 1'b0;
         mul_start_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         wptr_q      <= wptr_d;
         res_count_q <= res_count_d;
         a_q         <= a_d;
         b_q         <= b_d;
         prod_q      <= prod_d;
         re_q        <= re_d;
         mul_start_q <= mul_start_d;
      end
   end

   assign multiplicand_re = re_q;
   assign multiplier_re   = re_q;
   assign mul_start       = mul_start_q;
   assign mul_a           = a_q;
   assign mul_b           = b_q;
   assign res_we          = (state_q == ST_WRITE);
   assign res_waddr       = wptr_q;
   assign res_wdata       = (mode_q == MODE_ADD) ? sum : prod_q;
   assign res_count       = res_count_q;
   assign adder_op_done   = (state_q == ST_DONE);
   assign busy            = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule
